rb_stream_reader: RTL and testbench

- Consumer-side engine for the team's ringbuffer FIFO: drives `rd_en` and samples `data_out`/`empty`.
- On command, pops exactly `cmd_len` bytes and presents them on a valid/ready output stream.
- A 2-entry output buffer absorbs the FIFO's one-cycle read latency and downstream backpressure.
- Sits between the ringbuffer and any downstream byte consumer (serializer, packet builder).

---
 rtl/rb_pkg.sv | 22 ++
 rtl/rb_skid2.sv | 68 ++++++
 rtl/rb_stream_reader.sv | 176 +++++++++++++++++
 tb/tb_rb_stream_reader.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rb_pkg.sv
// Shared types and constants for the ringbuffer stream reader.
package rb_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int LEN_W_DEF  = 8;
    localparam int BUF_DEPTH  = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FLUSH = 2'd2
    } rd_state_e;

    // True when one more pop still fits: held + in-flight + new pop, less a same-cycle transfer.
    function automatic logic slot_free(input logic [1:0] buf_count,
                                       input logic       inflight,
                                       input logic       pop_out);
        return (({1'b0, buf_count} + {2'b00, inflight} + 3'd1) <=
                (3'(BUF_DEPTH) + {2'b00, pop_out}));
    endfunction

endpackage

// File: rtl/rb_skid2.sv
// Two-entry output buffer between the ringbuffer read port and the byte stream.
module rb_skid2
    import rb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic              valid,
    output logic [DATA_W-1:0] head_data,
    output logic [1:0]        count
);

    logic [DATA_W-1:0] head_r;
    logic [DATA_W-1:0] tail_r;
    logic [1:0]        count_r;
    logic              do_pop_s;
    logic              do_push_s;

    // A push into a full buffer is only honoured when the head leaves on the same edge.
    always_comb begin
        do_pop_s  = pop && (count_r != 2'd0);
        do_push_s = push && ((count_r != 2'd2) || do_pop_s);
    end

    // Head/tail storage and occupancy.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= 2'd0;
        end else begin
            case ({do_push_s, do_pop_s})
                2'b10: begin
                    if (count_r == 2'd0) begin
                        head_r <= push_data;
                    end else begin
                        tail_r <= push_data;
                    end
                    count_r <= count_r + 2'd1;
                end
                2'b01: begin
                    head_r  <= tail_r;
                    count_r <= count_r - 2'd1;
                end
                2'b11: begin
                    if (count_r == 2'd1) begin
                        head_r <= push_data;
                    end else begin
                        head_r <= tail_r;
                        tail_r <= push_data;
                    end
                end
                default: begin
                    count_r <= count_r;
                end
            endcase
        end
    end

    assign valid     = (count_r != 2'd0);
    assign head_data = head_r;
    assign count     = count_r;

endmodule

// File: rtl/rb_stream_reader.sv
// Drains cmd_len bytes from the ringbuffer onto a valid/ready byte stream.
// Define RB_READER_STATS_EN to add saturating transfer and stall counters.
module rb_stream_reader
    import rb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int LEN_W  = LEN_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_start,
    input  logic [LEN_W-1:0]  cmd_len,
    output logic              busy,
    output logic              done,
    output logic              rb_rd_en,
    input  logic [DATA_W-1:0] rb_data,
    input  logic              rb_empty,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DATA_W-1:0] m_data
`ifdef RB_READER_STATS_EN
    ,
    output logic [15:0]       stat_bytes,
    output logic [15:0]       stat_stall
`endif
);

    rd_state_e         state_r;
    rd_state_e         state_next_s;
    logic [LEN_W-1:0]  issue_left_r;
    logic              inflight_r;
    logic              busy_r;
    logic              done_r;
    logic              busy_next_s;
    logic              done_next_s;
    logic              rd_en_s;
    logic              xfer_s;
    logic              load_s;
    logic              last_pop_s;
    logic              buf_valid_s;
    logic [1:0]        buf_count_s;
    logic [DATA_W-1:0] buf_head_s;

    // The byte popped on one edge is on rb_data after it and is pushed on the next edge.
    rb_skid2 #(
        .DATA_W(DATA_W)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .push     (inflight_r),
        .push_data(rb_data),
        .pop      (xfer_s),
        .valid    (buf_valid_s),
        .head_data(buf_head_s),
        .count    (buf_count_s)
    );

    assign xfer_s     = buf_valid_s && m_ready;
    assign load_s     = (state_r == IDLE) && cmd_start && (cmd_len != '0);
    assign last_pop_s = rd_en_s && (issue_left_r == LEN_W'(1));

    // Pop request: draining, data present, bytes still owed and room for one more.
    always_comb begin
        rd_en_s = 1'b0;
        if ((state_r == DRAIN) && !rb_empty && (issue_left_r != '0) &&
            slot_free(buf_count_s, inflight_r, xfer_s)) begin
            rd_en_s = 1'b1;
        end else begin
            rd_en_s = 1'b0;
        end
    end

    // Burst sequencing: next state, busy and the done pulse.
    always_comb begin
        state_next_s = state_r;
        busy_next_s  = busy_r;
        done_next_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (load_s) begin
                    state_next_s = DRAIN;
                    busy_next_s  = 1'b1;
                end else if (cmd_start) begin
                    done_next_s  = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            DRAIN: begin
                if (last_pop_s) begin
                    state_next_s = FLUSH;
                end else begin
                    state_next_s = DRAIN;
                end
            end
            FLUSH: begin
                if ((buf_count_s == 2'd0) && !inflight_r) begin
                    state_next_s = IDLE;
                    busy_next_s  = 1'b0;
                    done_next_s  = 1'b1;
                end else begin
                    state_next_s = FLUSH;
                end
            end
            default: begin
                state_next_s = IDLE;
                busy_next_s  = 1'b0;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Issue counter, read-latency tracker and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            issue_left_r <= '0;
            inflight_r   <= 1'b0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            if (load_s) begin
                issue_left_r <= cmd_len;
            end else if (rd_en_s) begin
                issue_left_r <= issue_left_r - LEN_W'(1);
            end else begin
                issue_left_r <= issue_left_r;
            end
            inflight_r <= rd_en_s;
            busy_r     <= busy_next_s;
            done_r     <= done_next_s;
        end
    end

`ifdef RB_READER_STATS_EN
    logic [15:0] stat_bytes_r;
    logic [15:0] stat_stall_r;

    // Saturating counters for delivered bytes and starved drain cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_bytes_r <= 16'h0000;
            stat_stall_r <= 16'h0000;
        end else begin
            if (xfer_s && (stat_bytes_r != 16'hFFFF)) begin
                stat_bytes_r <= stat_bytes_r + 16'h0001;
            end else begin
                stat_bytes_r <= stat_bytes_r;
            end
            if ((state_r == DRAIN) && rb_empty && (issue_left_r != '0) &&
                (stat_stall_r != 16'hFFFF)) begin
                stat_stall_r <= stat_stall_r + 16'h0001;
            end else begin
                stat_stall_r <= stat_stall_r;
            end
        end
    end

    assign stat_bytes = stat_bytes_r;
    assign stat_stall = stat_stall_r;
`endif

    assign busy     = busy_r;
    assign done     = done_r;
    assign rb_rd_en = rd_en_s;
    assign m_valid  = buf_valid_s;
    assign m_data   = buf_head_s;

endmodule

// File: tb/tb_rb_stream_reader.sv
// Randomised bench for rb_stream_reader: ringbuffer model plus a byte-order scoreboard.
module tb_rb_stream_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_start = 1'b0;
    logic [7:0] cmd_len = 8'h00;
    logic       busy;
    logic       done;
    logic       rb_rd_en;
    logic [7:0] rb_data = 8'h00;
    logic       rb_empty = 1'b1;
    logic       m_valid;
    logic       m_ready = 1'b0;
    logic [7:0] m_data;
`ifdef RB_READER_STATS_EN
    logic [15:0] stat_bytes;
    logic [15:0] stat_stall;
`endif

    always #5 clk = ~clk;

    rb_stream_reader #(
        .DATA_W(8),
        .LEN_W (8)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .cmd_start(cmd_start),
        .cmd_len  (cmd_len),
        .busy     (busy),
        .done     (done),
        .rb_rd_en (rb_rd_en),
        .rb_data  (rb_data),
        .rb_empty (rb_empty),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data)
`ifdef RB_READER_STATS_EN
        ,
        .stat_bytes(stat_bytes),
        .stat_stall(stat_stall)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Ringbuffer model: pending writes, stored bytes, and every written byte in order.
    logic [7:0] wr_q[$];
    logic [7:0] fifo_q[$];
    logic [7:0] ref_q[$];

    initial begin
        forever begin
            @(posedge clk);
            if (rst) begin
                fifo_q.delete();
                wr_q.delete();
                ref_q.delete();
                rb_data  <= 8'h00;
                rb_empty <= 1'b1;
            end else begin
                if (rb_rd_en && !rb_empty) rb_data <= fifo_q.pop_front();
                while (wr_q.size() > 0) begin
                    fifo_q.push_back(wr_q[0]);
                    ref_q.push_back(wr_q[0]);
                    void'(wr_q.pop_front());
                end
                rb_empty <= (fifo_q.size() == 0);
            end
        end
    end

    // Monitor: observes the values that the next rising edge will act on.
    int cyc = 0;
    int pops_b = 0;
    int xfers_b = 0;
    int cur_len = 0;
    int start_cyc = 0;
    int first_xfer_cyc = 0;
    int last_xfer_cyc = 0;
    int done_cnt = 0;
    logic       prev_stall = 1'b0;
    logic       prev_done = 1'b0;
    logic [7:0] prev_data = 8'h00;

    initial begin
        logic [7:0] exp_b;
        forever begin
            @(negedge clk);
            cyc++;
            if (rst) begin
                prev_stall = 1'b0;
                prev_done  = 1'b0;
                pops_b     = 0;
                xfers_b    = 0;
            end else begin
                if (prev_stall) begin
                    check_val("hold_valid", m_valid, 1);
                    check_val("hold_data", m_data, prev_data);
                end
                if (prev_done) check_val("done_pulse", done, 0);
                if (m_valid) check_val("valid_busy", busy, 1);
                if (rb_rd_en) begin
                    check_val("rd_en_busy", busy, 1);
                    check_val("rd_en_empty", rb_empty, 0);
                    check_val("occupancy", (pops_b + 1 - xfers_b - int'(m_valid && m_ready)) <= 2, 1);
                    if (!rb_empty) pops_b++;
                end
                if (m_valid && m_ready) begin
                    if (ref_q.size() == 0) begin
                        check_val("xfer_unexpected", 0, 1);
                    end else begin
                        exp_b = ref_q.pop_front();
                        check_val("m_data", m_data, exp_b);
                    end
                    if (xfers_b == 0) first_xfer_cyc = cyc;
                    last_xfer_cyc = cyc;
                    xfers_b++;
                end
                if (done) begin
                    done_cnt++;
                    check_val("done_pops", pops_b, cur_len);
                    check_val("done_xfers", xfers_b, cur_len);
                    check_val("done_busy", busy, 0);
                    if (cur_len == 0) check_val("done_lat0", cyc - start_cyc, 1);
                    else check_val("done_lat", cyc - last_xfer_cyc, 2);
                end
                if (cmd_start && !busy) begin
                    cur_len   = int'(cmd_len);
                    pops_b    = 0;
                    xfers_b   = 0;
                    start_cyc = cyc;
                end
                prev_stall = m_valid && !m_ready;
                prev_data  = m_data;
                prev_done  = done;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [7:0] b);
        wr_q.push_back(b);
    endtask

    task automatic start_burst(input int len);
        cmd_start = 1'b1;
        cmd_len   = 8'(len);
        tick();
        cmd_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int d0;
        int n;
        d0 = done_cnt;
        n  = 0;
        while ((done_cnt == d0) && (n < budget)) begin
            tick();
            n++;
        end
        check_val(tag, int'(done_cnt != d0), 1);
    endtask

    initial begin
        int len;
        int pre;
        int rem;
        int n;
        int d0;
`ifdef RB_READER_STATS_EN
        logic [15:0] sb0;
        logic [15:0] ss0;
`endif
        repeat (3) tick();
        check_val("rst_busy", busy, 0);
        check_val("rst_done", done, 0);
        check_val("rst_rd_en", rb_rd_en, 0);
        check_val("rst_valid", m_valid, 0);
        check_val("rst_data", m_data, 0);
        rst = 1'b0;
        tick();

        // Full-rate burst.
        put(8'hAA); put(8'hBB); put(8'hCC); put(8'hDD);
        repeat (2) tick();
        m_ready = 1'b1;
        start_burst(4);
        wait_done("t1_done", 50);
        check_val("t1_first_lat", first_xfer_cyc - start_cyc, 3);
        check_val("t1_back2back", last_xfer_cyc - first_xfer_cyc, 3);
        check_val("t1_busy_after", busy, 0);

        // Backpressure: two pops then hold.
        put(8'h11); put(8'h22); put(8'h33);
        repeat (2) tick();
        m_ready = 1'b0;
        start_burst(3);
        repeat (6) tick();
        check_val("t2_pops_held", pops_b, 2);
        check_val("t2_valid", m_valid, 1);
        check_val("t2_data", m_data, 8'h11);
        m_ready = 1'b1;
        wait_done("t2_done", 50);

        // Starved ringbuffer mid-burst.
        put(8'h55);
        repeat (2) tick();
`ifdef RB_READER_STATS_EN
        sb0 = stat_bytes;
        ss0 = stat_stall;
`endif
        start_burst(2);
        repeat (5) tick();
        check_val("t3_stall_rd_en", rb_rd_en, 0);
        check_val("t3_stall_empty", rb_empty, 1);
        check_val("t3_busy", busy, 1);
        put(8'h66);
        wait_done("t3_done", 50);
`ifdef RB_READER_STATS_EN
        check_val("t6_stat_bytes", stat_bytes - sb0, 2);
        check_val("t6_stat_stall", (stat_stall - ss0) >= 16'd4, 1);
`endif

        // Zero-length command and stray start during a burst.
        start_burst(0);
        wait_done("t4_done0", 5);
        check_val("t4_valid0", m_valid, 0);
        put(8'h01); put(8'h02); put(8'h03); put(8'h04);
        repeat (2) tick();
        m_ready = 1'b0;
        start_burst(4);
        tick();
        start_burst(5);
        m_ready = 1'b1;
        wait_done("t4_done", 50);
        check_val("t4_fifo_left", rb_empty, 1);

        // Reset in the middle of a burst.
        put(8'hA1); put(8'hA2); put(8'hA3); put(8'hA4);
        repeat (2) tick();
        start_burst(4);
        n = 0;
        while ((xfers_b < 2) && (n < 30)) begin
            tick();
            n++;
        end
        check_val("t5_reach2", int'(xfers_b >= 2), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_val("t5_busy", busy, 0);
        check_val("t5_done", done, 0);
        check_val("t5_rd_en", rb_rd_en, 0);
        check_val("t5_valid", m_valid, 0);
        check_val("t5_data", m_data, 0);
        d0 = done_cnt;
        repeat (5) tick();
        check_val("t5_no_done", done_cnt, d0);
        put(8'h77);
        repeat (2) tick();
        start_burst(1);
        wait_done("t5_done_after", 50);

        // Random bursts with random supply and backpressure.
        for (int it = 0; it < 25; it++) begin
            len = $urandom_range(0, 10);
            pre = $urandom_range(0, len);
            for (int k = 0; k < pre; k++) put(8'($urandom));
            rem = len - pre;
            tick();
            m_ready = ($urandom_range(0, 3) != 0);
            d0 = done_cnt;
            start_burst(len);
            n = 0;
            while ((done_cnt == d0) && (n < 400)) begin
                m_ready = ($urandom_range(0, 3) != 0);
                if ((rem > 0) && ($urandom_range(0, 2) == 0)) begin
                    put(8'($urandom));
                    rem--;
                end
                tick();
                n++;
            end
            check_val("rand_done", int'(done_cnt != d0), 1);
        end

        m_ready = 1'b1;
        repeat (3) tick();
        check_val("end_scoreboard", ref_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
